// File: rtl/deadtime_generator_4bit_pkg.sv
// Shared types and constants for the two-leg dead-time generator.
// Leg FSM state encoding and gate bit positions on the top-level o_gate bus.
package deadtime_generator_4bit_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DT_H = 3'd1,
    HIGH = 3'd2,
    DT_L = 3'd3,
    LOW  = 3'd4
  } leg_state_t;

  localparam int unsigned LEG0_H = 0;
  localparam int unsigned LEG0_L = 1;
  localparam int unsigned LEG1_H = 2;
  localparam int unsigned LEG1_L = 3;

endpackage

// File: rtl/deadtime_generator_4bit_leg.sv
// One half-bridge leg: dead-time insertion and minimum on-time enforcement.
// Outputs are registered and follow the state being entered on each edge.
module deadtime_leg
  import deadtime_generator_4bit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_cmd,
  input  logic [CNT_W-1:0] dead_time,
  input  logic [CNT_W-1:0] min_on,
  output logic             o_high,
  output logic             o_low,
  output logic             o_dead
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  leg_state_t       state;
  logic [CNT_W-1:0] dt_cnt;
  logic [CNT_W-1:0] on_cnt;
  logic [CNT_W-1:0] dt_load;
  logic [CNT_W-1:0] on_min;
  logic             on_done;

  // Zero-valued settings behave as one cycle.
  always_comb begin
    dt_load = (dead_time == '0) ? ONE : dead_time;
    on_min  = (min_on == '0) ? ONE : min_on;
    on_done = (on_cnt >= on_min);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || !i_enable) begin
      state  <= IDLE;
      dt_cnt <= '0;
      on_cnt <= '0;
      o_high <= 1'b0;
      o_low  <= 1'b0;
      o_dead <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          dt_cnt <= dt_load;
          o_dead <= 1'b1;
          state  <= i_cmd ? DT_H : DT_L;
        end
        DT_H: begin
          if (dt_cnt == ONE) begin
            state  <= HIGH;
            on_cnt <= ONE;
            o_dead <= 1'b0;
            o_high <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - ONE;
          end
        end
        HIGH: begin
          if (!i_cmd && on_done) begin
            state  <= DT_L;
            dt_cnt <= dt_load;
            on_cnt <= '0;
            o_high <= 1'b0;
            o_dead <= 1'b1;
          end else if (on_cnt != '1) begin
            on_cnt <= on_cnt + ONE;
          end
        end
        DT_L: begin
          if (dt_cnt == ONE) begin
            state  <= LOW;
            on_cnt <= ONE;
            o_dead <= 1'b0;
            o_low  <= 1'b1;
          end else begin
            dt_cnt <= dt_cnt - ONE;
          end
        end
        LOW: begin
          if (i_cmd && on_done) begin
            state  <= DT_H;
            dt_cnt <= dt_load;
            on_cnt <= '0;
            o_low  <= 1'b0;
            o_dead <= 1'b1;
          end else if (on_cnt != '1) begin
            on_cnt <= on_cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          dt_cnt <= '0;
          on_cnt <= '0;
          o_high <= 1'b0;
          o_low  <= 1'b0;
          o_dead <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/deadtime_generator_4bit.sv
// Two independent half-bridge legs turning switching commands into four
// gate drives with programmable dead time and minimum on-time.
module deadtime_generator_4bit
  import deadtime_generator_4bit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [1:0]       i_cmd,
  input  logic [CNT_W-1:0] dead_time,
  input  logic [CNT_W-1:0] min_on,
  output logic [3:0]       o_gate,
  output logic [1:0]       o_dead
);

  deadtime_leg #(.CNT_W(CNT_W)) u_leg0 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_cmd     (i_cmd[0]),
    .dead_time (dead_time),
    .min_on    (min_on),
    .o_high    (o_gate[LEG0_H]),
    .o_low     (o_gate[LEG0_L]),
    .o_dead    (o_dead[0])
  );

  deadtime_leg #(.CNT_W(CNT_W)) u_leg1 (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_cmd     (i_cmd[1]),
    .dead_time (dead_time),
    .min_on    (min_on),
    .o_high    (o_gate[LEG1_H]),
    .o_low     (o_gate[LEG1_L]),
    .o_dead    (o_dead[1])
  );

endmodule

// File: tb/tb_deadtime_generator_4bit.sv
// Scoreboard bench: directed scenarios plus random soak, checked cycle by cycle
// against a timing-rule model of each leg.
module tb_deadtime_generator_4bit;

  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_enable;
  logic [1:0]       i_cmd;
  logic [CNT_W-1:0] dead_time;
  logic [CNT_W-1:0] min_on;
  logic [3:0]       o_gate;
  logic [1:0]       o_dead;

  always #5 i_clk = ~i_clk;

  deadtime_generator_4bit #(.CNT_W(CNT_W)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (i_enable),
    .i_cmd     (i_cmd),
    .dead_time (dead_time),
    .min_on    (min_on),
    .o_gate    (o_gate),
    .o_dead    (o_dead)
  );

  typedef struct packed {
    logic [3:0] gate;
    logic [1:0] dead;
  } exp_t;

  exp_t sb[$];
  exp_t got_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;
  bit   done = 1'b0;

  // Model per leg: side +1 high, -1 low, 0 off; dead_left counts remaining
  // dead cycles toward tgt; held counts cycles the current gate has been on.
  int side[2];
  int dead_left[2];
  int tgt[2];
  int held[2];

  task automatic model_step(input bit rst_n, input bit en, input logic [1:0] cmd,
                            input int dt, input int mo, output exp_t e);
    int d;
    int m;
    int want;
    d = (dt == 0) ? 1 : dt;
    m = (mo == 0) ? 1 : mo;
    e = '0;
    for (int n = 0; n < 2; n++) begin
      want = cmd[n] ? 1 : -1;
      if (!rst_n || !en) begin
        side[n] = 0; dead_left[n] = 0; held[n] = 0;
      end else if (dead_left[n] > 0) begin
        dead_left[n]--;
        if (dead_left[n] == 0) begin
          side[n] = tgt[n]; held[n] = 1;
        end
      end else if (side[n] == 0) begin
        tgt[n] = want; dead_left[n] = d;
      end else if (want != side[n] && held[n] >= m) begin
        side[n] = 0; tgt[n] = want; dead_left[n] = d; held[n] = 0;
      end else begin
        held[n]++;
      end
      e.gate[2*n]   = (side[n] == 1);
      e.gate[2*n+1] = (side[n] == -1);
      e.dead[n]     = (dead_left[n] > 0);
    end
  endtask

  task automatic cyc(input bit rst_n, input bit en, input logic [1:0] cmd,
                     input int dt, input int mo);
    exp_t e;
    i_reset   = rst_n;
    i_enable  = en;
    i_cmd     = cmd;
    dead_time = CNT_W'(dt);
    min_on    = CNT_W'(mo);
    model_step(rst_n, en, cmd, dt, mo, e);
    sb.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic run(input int n, input bit en, input logic [1:0] cmd,
                     input int dt, input int mo);
    repeat (n) cyc(1'b1, en, cmd, dt, mo);
  endtask

  // Monitor: one expected response per clock edge.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      cyc_no++;
      if (sb.size() == 0) begin
        if (!done) begin
          tests++; fails++;
          $display("FAIL sb_empty cycle=%0d", cyc_no);
        end
      end else begin
        got_e = sb.pop_front();
        tests++;
        if (o_gate !== got_e.gate || o_dead !== got_e.dead) begin
          fails++;
          $display("FAIL sb_cmp cycle=%0d gate=%b dead=%b expected gate=%b dead=%b",
                   cyc_no, o_gate, o_dead, got_e.gate, got_e.dead);
        end
        tests++;
        if ((o_gate[0] & o_gate[1]) !== 1'b0 || (o_gate[2] & o_gate[3]) !== 1'b0) begin
          fails++;
          $display("FAIL overlap cycle=%0d gate=%b expected no leg with both gates", cyc_no, o_gate);
        end
      end
    end
  end

  int         r_dt;
  int         r_mo;
  logic [1:0] r_cmd;
  bit         r_en;
  bit         r_rn;

  initial begin
    for (int n = 0; n < 2; n++) begin
      side[n] = 0; dead_left[n] = 0; tgt[n] = 0; held[n] = 0;
    end

    // Reset then start-up through the dead phase.
    repeat (3) cyc(1'b0, 1'b1, 2'b01, 4, 1);
    run(30, 1'b1, 2'b01, 4, 1);

    // Dead time of 5 on a leg0 high-to-low switch.
    run(20, 1'b1, 2'b01, 5, 1);
    run(15, 1'b1, 2'b00, 5, 1);

    // min_on hold: revert 3 cycles into LOW and stay.
    run(20, 1'b1, 2'b01, 5, 10);
    run(8, 1'b1, 2'b00, 5, 10);
    run(25, 1'b1, 2'b01, 5, 10);
    // Short glitch shortly after entering LOW is ignored.
    run(8, 1'b1, 2'b00, 5, 10);
    run(2, 1'b1, 2'b01, 5, 10);
    run(20, 1'b1, 2'b00, 5, 10);

    // Zero settings with a fast toggle.
    for (int i = 0; i < 12; i++) run(2, 1'b1, (i % 2 == 0) ? 2'b11 : 2'b00, 0, 0);

    // Disable during dead phase, then during HIGH before min_on.
    run(20, 1'b1, 2'b00, 6, 10);
    run(2, 1'b1, 2'b11, 6, 10);
    run(1, 1'b0, 2'b11, 6, 10);
    run(10, 1'b1, 2'b11, 6, 10);
    run(1, 1'b0, 2'b11, 6, 10);
    run(20, 1'b1, 2'b11, 6, 10);
    // Reset mid dead phase.
    run(3, 1'b1, 2'b00, 6, 10);
    cyc(1'b0, 1'b1, 2'b00, 6, 10);
    run(15, 1'b1, 2'b10, 6, 10);

    // Random soak.
    r_dt = 3; r_mo = 2; r_cmd = 2'b00;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 99) == 0) r_dt = $urandom_range(0, 7);
      if ($urandom_range(0, 99) == 0) r_mo = $urandom_range(0, 7);
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 5) == 0) r_cmd[b] = ~r_cmd[b];
      r_en = ($urandom_range(0, 59) != 0);
      r_rn = ($urandom_range(0, 299) != 0);
      cyc(r_rn, r_en, r_cmd, r_dt, r_mo);
    end

    done = 1'b1;
    @(posedge i_clk);
    #3;
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL sb_drain left=%0d expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
